// File: rtl/ahbl_pkg.sv
// AHB-Lite shared definitions: transfer/size encodings, response
// states and the byte-lane mask helper.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        RSP_OK   = 2'd0,
        RSP_ERR1 = 2'd1,
        RSP_ERR2 = 2'd2
    } rsp_e;

    // Lanes touched by a transfer of 2**size bytes at byte offset lsb,
    // for data paths up to 64 bits; callers slice to their width.
    function automatic logic [7:0] size_mask(
        input logic [2:0] lsb,
        input logic [2:0] size
    );
        logic [7:0] base;
        logic [2:0] off;
        unique case (size)
            HSIZE_BYTE: base = 8'h01;
            HSIZE_HALF: base = 8'h03;
            HSIZE_WORD: base = 8'h0f;
            default:    base = 8'hff;
        endcase
        off = lsb & ~((3'd1 << size) - 3'd1);
        return base << off;
    endfunction

endpackage

// File: rtl/ahbl_excl_monitor.sv
// Per-master exclusive reservation slots, updated in address-phase
// order; pass result is held for the following data phase.
module ahbl_excl_monitor
    import ahbl_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int W_SRAM_ADDR = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hready_i,
    input  logic                   valid_i,
    input  logic                   write_i,
    input  logic                   excl_i,
    input  logic [7:0]             master_i,
    input  logic [W_SRAM_ADDR-1:0] addr_i,
    output logic                   pass_o
);

    logic [N_MASTERS-1:0]                  slot_v_q, slot_v_d;
    logic [N_MASTERS-1:0][W_SRAM_ADDR-1:0] slot_a_q, slot_a_d;
    logic                                  pass_q, pass_d;
    logic                                  own, hit, clr, set;

    always_comb begin
        own = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (master_i == 8'(i)) begin
                own = 1'b1;
                hit = slot_v_q[i] && (slot_a_q[i] == addr_i);
            end
        end
        pass_d = valid_i && excl_i && (write_i ? hit : own);
        clr    = valid_i && write_i && (!excl_i || hit);
        set    = valid_i && !write_i && excl_i && own;
        slot_v_d = slot_v_q;
        slot_a_d = slot_a_q;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (clr && slot_a_q[i] == addr_i)
                slot_v_d[i] = 1'b0;
        end
        // Set is applied last so it wins over a clear of the same slot
        for (int i = 0; i < N_MASTERS; i++) begin
            if (set && master_i == 8'(i)) begin
                slot_v_d[i] = 1'b1;
                slot_a_d[i] = addr_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_q <= '0;
            slot_a_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            slot_v_q <= slot_v_d;
            slot_a_q <= slot_a_d;
            if (hready_i)
                pass_q <= pass_d;
        end
    end

    assign pass_o = pass_q;

endmodule

// File: rtl/ahbl_sram_excl.sv
// Zero-wait AHB-Lite SRAM responder with one-entry write buffer,
// read-data merging and an exclusive-access monitor.
module ahbl_sram_excl
    import ahbl_pkg::*;
#(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 4096,
    parameter int N_MASTERS   = 4,
    parameter int W_SRAM_ADDR = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ahbls_hready,
    output logic                   ahbls_hready_resp,
    output logic                   ahbls_hresp,
    input  logic [W_ADDR-1:0]      ahbls_haddr,
    input  logic                   ahbls_hwrite,
    input  logic [1:0]             ahbls_htrans,
    input  logic [2:0]             ahbls_hsize,
    input  logic [2:0]             ahbls_hburst,
    input  logic [3:0]             ahbls_hprot,
    input  logic                   ahbls_hmastlock,
    input  logic [W_DATA-1:0]      ahbls_hwdata,
    output logic [W_DATA-1:0]      ahbls_hrdata,
    input  logic                   ahbls_hexcl,
    input  logic [7:0]             ahbls_hmaster,
    output logic                   ahbls_hexokay,
    output logic [W_SRAM_ADDR-1:0] sram_addr,
    output logic [W_DATA-1:0]      sram_wdata,
    output logic [W_DATA/8-1:0]    sram_wbmask,
    output logic                   sram_wen,
    output logic                   sram_ren,
    input  logic [W_DATA-1:0]      sram_rdata
);

    localparam int W_BYTES = W_DATA / 8;
    localparam int W_LANE  = $clog2(W_BYTES);

    logic                   ap_acc, ap_err, ap_ok, ap_rd, ap_wr;
    logic [W_SRAM_ADDR-1:0] ap_addr;
    logic [7:0]             ap_mask8;
    logic [W_BYTES-1:0]     ap_mask;

    rsp_e                   rsp_q, rsp_d;

    logic                   dph_rd_q, dph_wr_q, dph_ex_q;
    logic [W_SRAM_ADDR-1:0] dph_addr_q;
    logic [W_BYTES-1:0]     dph_mask_q;

    logic                   wb_v_q;
    logic [W_SRAM_ADDR-1:0] wb_addr_q;
    logic [W_DATA-1:0]      wb_data_q;
    logic [W_BYTES-1:0]     wb_mask_q;

    logic                   mon_pass, wr_now;
    logic [W_DATA-1:0]      rd_merged;

    logic                   unused;
    assign unused = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                      ahbls_haddr, ahbls_htrans[0]};

    assign ap_acc   = ahbls_hready && ahbls_htrans[1];
    assign ap_err   = ap_acc && (ahbls_hsize > 3'(W_LANE));
    assign ap_ok    = ap_acc && !ap_err;
    assign ap_rd    = ap_ok && !ahbls_hwrite;
    assign ap_wr    = ap_ok && ahbls_hwrite;
    assign ap_addr  = ahbls_haddr[W_LANE +: W_SRAM_ADDR];
    assign ap_mask8 = size_mask(3'(ahbls_haddr[W_LANE-1:0]), ahbls_hsize);
    assign ap_mask  = ap_mask8[W_BYTES-1:0];

    always_comb begin
        rsp_d = RSP_OK;
        unique case (rsp_q)
            RSP_ERR1: rsp_d = RSP_ERR2;
            default:  rsp_d = ap_err ? RSP_ERR1 : RSP_OK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_q <= RSP_OK;
        else
            rsp_q <= rsp_d;
    end

    assign ahbls_hready_resp = (rsp_q != RSP_ERR1);
    assign ahbls_hresp       = (rsp_q != RSP_OK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_rd_q   <= 1'b0;
            dph_wr_q   <= 1'b0;
            dph_ex_q   <= 1'b0;
            dph_addr_q <= '0;
            dph_mask_q <= '0;
        end else if (ahbls_hready) begin
            dph_rd_q   <= ap_rd;
            dph_wr_q   <= ap_wr;
            dph_ex_q   <= ap_ok && ahbls_hexcl;
            dph_addr_q <= ap_addr;
            dph_mask_q <= ap_mask;
        end
    end

    ahbl_excl_monitor #(
        .N_MASTERS   (N_MASTERS),
        .W_SRAM_ADDR (W_SRAM_ADDR)
    ) u_mon (
        .clk      (clk),
        .rst_n    (rst_n),
        .hready_i (ahbls_hready),
        .valid_i  (ap_ok),
        .write_i  (ahbls_hwrite),
        .excl_i   (ahbls_hexcl),
        .master_i (ahbls_hmaster),
        .addr_i   (ap_addr),
        .pass_o   (mon_pass)
    );

    assign ahbls_hexokay = mon_pass;
    assign wr_now = dph_wr_q && (!dph_ex_q || mon_pass) && ahbls_hready;

    // Data goes straight to SRAM when the port is free; only a read
    // address phase in the same cycle parks it in the buffer. The buffer
    // then drains before the next write data phase can arrive.
    assign sram_ren    = ap_rd;
    assign sram_wen    = !ap_rd && (wb_v_q || wr_now);
    assign sram_wdata  = wb_v_q ? wb_data_q : ahbls_hwdata;
    assign sram_wbmask = wb_v_q ? wb_mask_q : dph_mask_q;
    assign sram_addr   = ap_rd  ? ap_addr :
                         wb_v_q ? wb_addr_q : dph_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_v_q    <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_mask_q <= '0;
        end else if (wr_now && ap_rd) begin
            wb_v_q    <= 1'b1;
            wb_addr_q <= dph_addr_q;
            wb_data_q <= ahbls_hwdata;
            wb_mask_q <= dph_mask_q;
        end else if (wb_v_q && !ap_rd) begin
            wb_v_q    <= 1'b0;
        end
    end

    always_comb begin
        rd_merged = sram_rdata;
        if (wb_v_q && wb_addr_q == dph_addr_q) begin
            for (int b = 0; b < W_BYTES; b++) begin
                if (wb_mask_q[b])
                    rd_merged[8*b +: 8] = wb_data_q[8*b +: 8];
            end
        end
        ahbls_hrdata = dph_rd_q ? rd_merged : '0;
    end

endmodule

// File: tb/tb_ahbl_sram_excl.sv
// Randomized bench for ahbl_sram_excl against a sequential memory and
// reservation model.
module tb_ahbl_sram_excl;

    localparam int DEPTH = 4096;
    localparam int N_M   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hready, hready_resp, hresp, hwrite, hmastlock, hexcl, hexokay;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [7:0]  hmaster;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [3:0]  sram_wbmask;
    logic        sram_wen, sram_ren;

    always #5 clk = ~clk;
    assign hready = hready_resp;

    ahbl_sram_excl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ahbls_hready      (hready),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hresp       (hresp),
        .ahbls_haddr       (haddr),
        .ahbls_hwrite      (hwrite),
        .ahbls_htrans      (htrans),
        .ahbls_hsize       (hsize),
        .ahbls_hburst      (hburst),
        .ahbls_hprot       (hprot),
        .ahbls_hmastlock   (hmastlock),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata),
        .ahbls_hexcl       (hexcl),
        .ahbls_hmaster     (hmaster),
        .ahbls_hexokay     (hexokay),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
        .sram_wbmask       (sram_wbmask),
        .sram_wen          (sram_wen),
        .sram_ren          (sram_ren),
        .sram_rdata        (sram_rdata)
    );

    logic [31:0] sram_mem [DEPTH];

    always @(posedge clk) begin
        if (sram_wen)
            for (int b = 0; b < 4; b++)
                if (sram_wbmask[b])
                    sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        if (sram_ren)
            sram_rdata <= sram_mem[sram_addr];
    end

    logic [31:0] ref_mem [DEPTH];
    bit          res_v [N_M];
    int          res_a [N_M];

    bit          p_val, p_wr, p_rd, p_ok;
    logic [31:0] p_wdata, p_exp_rd;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        htrans = 2'b00;
        hwrite = 1'b0;
        hexcl  = 1'b0;
        hsize  = 3'd2;
        haddr  = 32'h0;
    endtask

    // Spec-level effect of one transfer, applied in issue order
    task automatic model(input bit wr, input bit ex, input int m,
                         input logic [31:0] a, input int sz,
                         input logic [31:0] wd);
        int  w, nb, base;
        bit  pass;
        w  = int'((a >> 2) % DEPTH);
        nb = 1 << sz;
        base = (int'(a % 4) / nb) * nb;
        if (!wr) begin
            p_rd = 1'b1;
            p_exp_rd = ref_mem[w];
            if (ex && m < N_M) begin
                res_v[m] = 1'b1;
                res_a[m] = w;
            end
            p_ok = ex && (m < N_M);
        end else begin
            pass = !ex || (m < N_M && res_v[m] && res_a[m] == w);
            if (pass) begin
                for (int b = 0; b < 4; b++)
                    if (b >= base && b < base + nb)
                        ref_mem[w][8*b +: 8] = wd[8*b +: 8];
                for (int i = 0; i < N_M; i++)
                    if (res_v[i] && res_a[i] == w)
                        res_v[i] = 1'b0;
            end
            p_wr = 1'b1;
            p_wdata = wd;
            p_ok = ex && pass;
        end
    endtask

    task automatic step(input bit act, input bit wr, input bit ex,
                        input int m, input logic [31:0] a, input int sz,
                        input logic [31:0] wd);
        @(negedge clk);
        if (p_val) begin
            chk("hready", 32'(hready_resp), 32'd1);
            chk("hresp", 32'(hresp), 32'd0);
            if (p_rd)
                chk("hrdata", hrdata, p_exp_rd);
            chk("hexokay", 32'(hexokay), 32'(p_ok));
        end
        hwdata = p_wr ? p_wdata : 32'h0;
        p_val = act;
        p_wr = 1'b0;
        p_rd = 1'b0;
        p_ok = 1'b0;
        if (act) begin
            htrans  = 2'b10;
            hwrite  = wr;
            hexcl   = ex;
            hmaster = 8'(m);
            haddr   = a;
            hsize   = 3'(sz);
            model(wr, ex, m, a, sz, wd);
        end else begin
            drive_idle();
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 32'h0, 2, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        for (int i = 0; i < N_M; i++) res_v[i] = 1'b0;
        sram_rdata = 32'h0;
        hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0;
        hmaster = 8'd0; hwdata = 32'h0;
        p_val = 0; p_wr = 0; p_rd = 0; p_ok = 0;
        drive_idle();

        repeat (2) @(negedge clk);
        chk("rst_hready", 32'(hready_resp), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hexokay", 32'(hexokay), 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_wen_ren", {30'd0, sram_wen, sram_ren}, 32'd0);
        rst_n = 1'b1;

        // Single write then read
        step(1, 1, 0, 0, 32'h10, 2, 32'hDEADBEEF);
        step(1, 0, 0, 0, 32'h10, 2, 32'h0);
        idle();
        chk("t1_rd", hrdata, 32'hDEADBEEF);

        // Back-to-back write, byte write, read: merged from the buffer
        step(1, 1, 0, 0, 32'h10, 2, 32'hDEADBEEF);
        step(1, 1, 0, 0, 32'h11, 0, 32'h0000AA00);
        step(1, 0, 0, 0, 32'h10, 2, 32'h0);
        #1 chk("t2_wen_rd_ap", 32'(sram_wen), 32'd0);
        idle();
        chk("t2_merge", hrdata, 32'hDEADAAEF);
        #1 chk("t2_commit", 32'(sram_wen), 32'd1);
        idle();

        // Exclusive pair by master 1
        step(1, 0, 1, 1, 32'h20, 2, 32'h0);
        step(1, 1, 1, 1, 32'h20, 2, 32'h12345678);
        step(1, 0, 0, 1, 32'h20, 2, 32'h0);
        idle();
        chk("t3_rd", hrdata, 32'h12345678);

        // Two masters race on one word
        step(1, 0, 1, 1, 32'h20, 2, 32'h0);
        step(1, 0, 1, 2, 32'h20, 2, 32'h0);
        step(1, 1, 1, 2, 32'h20, 2, 32'hA5A5A5A5);
        step(1, 1, 1, 1, 32'h20, 2, 32'h5A5A5A5A);
        step(1, 0, 0, 0, 32'h20, 2, 32'h0);
        chk("t4_m1_fail", 32'(hexokay), 32'd0);
        idle();
        chk("t4_rd", hrdata, 32'hA5A5A5A5);

        // Plain write by master 3 kills master 0 reservation
        step(1, 0, 1, 0, 32'h30, 2, 32'h0);
        step(1, 1, 0, 3, 32'h30, 2, 32'h33333333);
        step(1, 1, 1, 0, 32'h30, 2, 32'h44444444);
        step(1, 0, 0, 0, 32'h30, 2, 32'h0);
        idle();
        chk("t5_rd", hrdata, 32'h33333333);

        // Oversized transfer: two-cycle error, monitor untouched
        step(1, 0, 1, 1, 32'h40, 2, 32'h0);
        idle();
        @(negedge clk);
        htrans = 2'b10; hwrite = 1'b1; hexcl = 1'b1;
        hmaster = 8'd1; haddr = 32'h40; hsize = 3'd3;
        @(negedge clk);
        drive_idle();
        #1;
        chk("err1_hready", 32'(hready_resp), 32'd0);
        chk("err1_hresp", 32'(hresp), 32'd1);
        chk("err1_wen", 32'(sram_wen), 32'd0);
        @(negedge clk);
        chk("err2_hready", 32'(hready_resp), 32'd1);
        chk("err2_hresp", 32'(hresp), 32'd1);
        chk("err2_wen", 32'(sram_wen), 32'd0);
        step(1, 1, 1, 1, 32'h40, 2, 32'hCAFEF00D);
        step(1, 0, 0, 1, 32'h40, 2, 32'h0);
        idle();
        chk("err_rd", hrdata, 32'hCAFEF00D);

        // Reset during a write data phase
        step(1, 1, 0, 2, 32'h50, 2, 32'h11111111);
        idle();
        @(negedge clk);
        htrans = 2'b10; hwrite = 1'b1; hexcl = 1'b0;
        hmaster = 8'd2; haddr = 32'h50; hsize = 3'd2;
        @(negedge clk);
        drive_idle();
        hwdata = 32'h22222222;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_hready", 32'(hready_resp), 32'd1);
        chk("rst_mid_wen", 32'(sram_wen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_M; i++) res_v[i] = 1'b0;
        p_val = 0; p_wr = 0;
        step(1, 0, 0, 2, 32'h50, 2, 32'h0);
        idle();
        chk("rst_mid_rd", hrdata, 32'h11111111);

        // Random traffic on a few colliding words with address aliasing
        for (int n = 0; n < 600; n++) begin
            int          sz, w, m;
            logic [31:0] a;
            sz = $urandom_range(0, 2);
            w  = $urandom_range(8, 11);
            m  = $urandom_range(0, N_M);
            a  = ($urandom & 32'hFFFFC000) | 32'(w << 2) |
                 (32'($urandom_range(0, 3)) & ~(32'(1 << sz) - 1));
            step($urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom),
                 m, a, sz, $urandom);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahbl_sram_excl.md
Name: ahbl_sram_excl

Overview:
AHB-Lite slave (responder) fronting a single-port synchronous SRAM, with a per-master exclusive-access monitor driving hexokay. It is the downstream end of the busfabric and sits on the dst port of an arbiter or splitter. It consumes hexcl/hmaster and returns hexokay. Zero-wait-state reads and writes are achieved with a one-entry write buffer and read-data merging.

Parameters:
W_ADDR, 32, AHB address width
W_DATA, 32, data width (32 or 64)
DEPTH, 4096, SRAM depth in words
N_MASTERS, 4, number of reservation slots, indexed by hmaster
W_SRAM_ADDR, $clog2(DEPTH), SRAM word address width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ahbls_hready  in  1  bus-level HREADY
ahbls_hready_resp  out  1  slave HREADYOUT
ahbls_hresp  out  1  error response
ahbls_haddr  in  W_ADDR  address
ahbls_hwrite  in  1  write
ahbls_htrans  in  2  transfer type
ahbls_hsize  in  3  transfer size
ahbls_hburst  in  3  ignored
ahbls_hprot  in  4  ignored
ahbls_hmastlock  in  1  ignored
ahbls_hwdata  in  W_DATA  write data
ahbls_hrdata  out  W_DATA  read data
ahbls_hexcl  in  1  exclusive transfer
ahbls_hmaster  in  8  master ID
ahbls_hexokay  out  1  exclusive success
sram_addr  out  W_SRAM_ADDR  word address
sram_wdata  out  W_DATA  write data
sram_wbmask  out  W_DATA/8  byte write enables
sram_wen  out  1  write strobe
sram_ren  out  1  read strobe
sram_rdata  in  W_DATA  read data, valid 1 cycle after sram_ren

Behaviour:
- Reset: hready_resp=1, hresp=0, hexokay=0, hrdata=0; sram_wen=sram_ren=0; write buffer empty; all reservations invalid. Reset mid-transfer aborts the transfer with no SRAM write.
- Address phase accepted when ahbls_hready && htrans[1]. Captured: word addr = haddr[log2(W_DATA/8) +: W_SRAM_ADDR], byte lanes from haddr low bits and hsize, hwrite, hexcl, hmaster. Upper address bits are ignored, so addresses wrap modulo DEPTH.
- Error: hsize > log2(W_DATA/8) gives a two-cycle ERROR: cycle 1 hready_resp=0/hresp=1, cycle 2 hready_resp=1/hresp=1. No SRAM access and no monitor update.
- Read: sram_ren and sram_addr are driven combinationally in the accepted address phase. The data phase completes with no wait state; hrdata = sram_rdata, with bytes merged from the write buffer when the buffer is valid and its word address matches the read.
- Write: hwdata is captured into the write buffer (addr, data, bytemask) at the end of the data phase, with no wait state.
- Buffer commit: sram_wen=1 in any cycle where the buffer is valid and no read address phase is accepted; the buffer clears at that edge. A write address phase frees the SRAM port, so the buffer holds at most one entry.
- Exclusive monitor: one slot per hmaster < N_MASTERS, holding a valid bit and a word address.
  - Exclusive read: sets that master's slot to the word address; hexokay=1 in the data phase.
  - Exclusive write: passes if the master's slot is valid and matches the word address. On pass: the write is buffered, hexokay=1, and every slot matching that word is cleared.
  - Exclusive write fail: bytemask forced to 0 (no write), hexokay=0, hresp=OKAY.
  - Non-exclusive write: clears every slot matching that word; hexokay=0.
  - hmaster >= N_MASTERS: exclusive read sets no slot and returns hexokay=0; exclusive write fails.
  - Slots are evaluated in address-phase order. Same-cycle set and clear on one slot: the set wins.
- hexokay and hrdata are meaningful only in the final data-phase cycle (hready_resp=1).

Decomposition:
- Shared package ahbl_pkg: HTRANS_IDLE/BUSY/NSEQ/SEQ constants, HSIZE encodings, byte-mask-from-size function.
- Sub-module ahbl_excl_monitor holds the reservation slots:
  - inputs: addr-phase valid, write, excl, master, word addr
  - output: pass/fail for the data phase

Test Plan:
- Single read/write: write 0xDEADBEEF to 0x10, then read 0x10 → hrdata=0xDEADBEEF, hready_resp held 1 throughout.
- Back-to-back write 0x10 followed immediately by read 0x10 (byte write 0xAA at 0x11) → read returns merged data 0xDEADAAEF with no SRAM write in the read address cycle; the buffer commits the cycle after.
- Exclusive pair master 1 to 0x20 → read hexokay=1, write hexokay=1, SRAM updated.
- Masters 1 and 2 both exclusive-read 0x20; master 2 exclusive-writes (hexokay=1); master 1 exclusive-write → hexokay=0, SRAM value unchanged.
- Exclusive read by master 0, then non-exclusive write by master 3 to the same word → master 0 exclusive write fails (hexokay=0).
- hsize=3 on a 32-bit build → two-cycle ERROR (hresp=1, hready_resp 0 then 1); no sram_wen; monitor unchanged. Assert rst_n mid-write → no commit and hready_resp=1.
